act_pipe: RTL and testbench
===========================

# act_pipe

Parametrised multi-lane activation stage placed between the convolution/accumulator output and the pooling stage of the CNN datapath. It applies a run-time selectable activation (bypass, ReLU, clipped ReLU, leaky ReLU) to CH signed lanes per beat. It carries a valid/ready stream with full-throughput backpressure and reports a per-frame count of zero outputs for sparsity monitoring.

## Interface
- DATA_W, 8, signed width of each lane
- CH, 4, lanes per beat
- LEAKY_SHIFT, 3, arithmetic right-shift applied to negative inputs in leaky mode
- CNT_W, 16, width of the frame zero counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- mode  in  2  activation select, sampled with each accepted input beat
- clip_val  in  DATA_W  signed upper clip for clipped mode, sampled with each accepted beat
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  CH*DATA_W  packed lanes, lane i at bits [i*DATA_W +: DATA_W]
- s_last  in  1  final beat of a frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  CH*DATA_W  activated lanes, same packing
- m_last  out  1  final beat of frame
- m_zero_cnt  out  CNT_W  zero outputs in the frame so far, including the current beat; meaningful when m_valid && m_last

## Operation
- Modes: 0 bypass (Y=A); 1 ReLU (Y = A<0 ? 0 : A); 2 clipped ReLU (Y = min(max(A,0), clip_eff)); 3 leaky (Y = A<0 ? A>>>LEAKY_SHIFT : A).
- clip_eff = clip_val when clip_val ≥ 0, else 0.
- Leaky shift is arithmetic, rounding toward −inf: −1 → −1, −8 → −1, −9 → −2 at shift 3. No width growth, no saturation needed.
- Mode and clip_val travel with their beat. Changing them between beats needs no flush, and a beat in flight is unaffected.
- Zero counter:
  - Adds the number of lanes whose output equals 0 as each beat enters stage 2.
  - Saturates at 2^CNT_W−1.
  - The value presented with a beat includes that beat.
  - Clears to 0 after the m_last beat is handed off (m_valid && m_ready && m_last). The next frame starts at 0.
- A beat transfers on a port when its valid && ready are high in the same cycle.

## Timing
- Two-register pipeline: stage 1 captures the input, mode and clip; stage 2 holds the activated result. Latency is 2 cycles from input handshake to m_valid when m_ready is held high.
- Throughput is 1 beat/cycle with m_ready high.
- Ready chain:
  - stage k accepts a beat when it is empty or its content leaves the same cycle.
  - s_ready = !stage1_valid || stage2_can_load.
  - s_ready is combinational from state and m_ready. It must not depend on s_valid.
- Backpressure: with m_ready low, m_data, m_last and m_zero_cnt hold stable. Both stages fill, then s_ready drops. No beat is dropped or duplicated.
- Simultaneous input accept and output handoff in the same cycle are both honoured.
- Reset values (async assert, sync-safe deassert): m_valid=0, m_data=0, m_last=0, m_zero_cnt=0, internal valids=0. s_ready is forced 0 while rst_n is low and is 1 in the first cycle after release.
- Reset mid-frame discards all in-flight beats and the partial count. The next beat starts a fresh frame.

## Structure
- Shared package act_pkg:
  - mode constants ACT_BYPASS=0, ACT_RELU=1, ACT_CLIP=2, ACT_LEAKY=3
  - packed lane-access helper width constants
- Sub-module act_lane: one lane's combinational activation (A, mode, clip_eff → Y, is_zero), instantiated CH times in a generate loop.
- Top level owns the pipeline registers, the handshake logic and the zero counter.

## Test plan
- Parameters for all scenarios: DATA_W=8, CH=4, LEAKY_SHIFT=3.
- ReLU, m_ready=1, lanes {−5, 0, 7, −128} → m_data {0, 0, 7, 0} two cycles after accept; single-beat frame with s_last=1 → m_zero_cnt=3.
- Clip mode, clip_val=6, lanes {−1, 6, 7, 127} → {0, 6, 6, 6}. With clip_val=−3 the same lanes → {0, 0, 0, 0}.
- Leaky mode, lanes {−1, −8, −9, 50} → {−1, −1, −2, 50}. Bypass mode passes {−128, 127, 0, 1} unchanged.
- Backpressure: stream 10 beats with a counting pattern while m_ready toggles 1-0-0-1 → output order and values are exact; s_ready is low exactly while both stages are full; the held m_data is stable.
- Frame counter: 3-beat frame with 1, 2 and 4 zero lanes → m_zero_cnt=7 on the m_last beat; the next frame's first beat with 0 zeros shows 0. Back-to-back frames with no gap do not bleed counts.
- Drop rst_n mid-frame with both stages full → m_valid=0 and m_zero_cnt=0 immediately (asynchronously); after release the first output reflects only post-reset input.

Source files
------------

// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the activation pipeline.
//   act_mode_e - activation select encoding carried with each beat
//   MODE_W     - width of the mode field
//   lane_lo()  - LSB position of a lane inside a packed beat
package act_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      ACT_BYPASS = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_CLIP   = 2'd2,
      ACT_LEAKY  = 2'd3
   } act_mode_e;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational activation for one signed lane.
//   a        in   signed lane input
//   mode     in   activation select
//   clip_eff in   non-negative upper clip for clipped ReLU
//   y        out  activated lane
//   is_zero  out  y == 0
module act_lane
   import act_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int LEAKY_SHIFT = 3
) (
   input  logic signed [DATA_W-1:0] a,
   input  act_mode_e                mode,
   input  logic signed [DATA_W-1:0] clip_eff,
   output logic signed [DATA_W-1:0] y,
   output logic                     is_zero
);

   logic neg;

   assign neg = a[DATA_W-1];

   always_comb begin
      y = a;
      case (mode)
         ACT_BYPASS: y = a;
         ACT_RELU:   y = neg ? '0 : a;
         ACT_CLIP:   y = neg ? '0 : ((a > clip_eff) ? clip_eff : a);
         // arithmetic shift rounds toward -inf, so small negatives stay at -1
         ACT_LEAKY:  y = neg ? (a >>> LEAKY_SHIFT) : a;
      endcase
   end

   assign is_zero = (y == '0);

endmodule

// File: rtl/act_pipe.sv
// act_pipe: two-stage multi-lane activation with valid/ready backpressure
// and a per-frame zero-output counter.
//   clk, rst_n             clock, async active-low reset
//   mode, clip_val         activation select / clip, captured with each beat
//   s_valid/s_ready        input handshake; s_data packed lanes, s_last frame end
//   m_valid/m_ready        output handshake; m_data activated lanes, m_last frame end
//   m_zero_cnt             zero lanes in the frame so far, including this beat
module act_pipe
   import act_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CH          = 4,
   parameter int LEAKY_SHIFT = 3,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MODE_W-1:0]    mode,
   input  logic [DATA_W-1:0]    clip_val,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [CH*DATA_W-1:0] s_data,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CH*DATA_W-1:0] m_data,
   output logic                 m_last,
   output logic [CNT_W-1:0]     m_zero_cnt
);

   localparam int BUS_W = CH * DATA_W;
   localparam int ZW    = $clog2(CH + 1);

   logic                     s1_valid;
   logic [BUS_W-1:0]         s1_data;
   logic                     s1_last;
   act_mode_e                s1_mode;
   logic signed [DATA_W-1:0] s1_clip;

   logic signed [DATA_W-1:0] clip_eff;
   logic [BUS_W-1:0]         act_data;
   logic [CH-1:0]            lane_zero;

   logic                     s2_can_load;
   logic                     s_fire;
   logic                     m_fire_last;

   logic [ZW-1:0]            zero_sum;
   logic [CNT_W-1:0]         cnt_base;
   logic [CNT_W:0]           cnt_sum;
   logic [CNT_W-1:0]         cnt_next;

   assign s2_can_load = !m_valid || m_ready;
   // rst_n gates s_ready so nothing is offered as accepted while in reset
   assign s_ready     = rst_n && (!s1_valid || s2_can_load);
   assign s_fire      = s_valid && s_ready;
   assign m_fire_last = m_valid && m_ready && m_last;

   assign clip_eff = s1_clip[DATA_W-1] ? '0 : s1_clip;

   for (genvar g = 0; g < CH; g++) begin : g_lane
      act_lane #(
         .DATA_W      (DATA_W),
         .LEAKY_SHIFT (LEAKY_SHIFT)
      ) u_lane (
         .a        (s1_data[lane_lo(g, DATA_W) +: DATA_W]),
         .mode     (s1_mode),
         .clip_eff (clip_eff),
         .y        (act_data[lane_lo(g, DATA_W) +: DATA_W]),
         .is_zero  (lane_zero[g])
      );
   end

   always_comb begin
      zero_sum = '0;
      for (int i = 0; i < CH; i++) begin
         zero_sum = zero_sum + ZW'(lane_zero[i]);
      end
   end

   // A beat entering stage 2 while the previous frame's last beat leaves
   // starts the new frame from zero.
   assign cnt_base = m_fire_last ? '0 : m_zero_cnt;
   assign cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(zero_sum);
   assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_mode  <= ACT_BYPASS;
         s1_clip  <= '0;
      end else if (s_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= s_data;
         s1_last  <= s_last;
         s1_mode  <= act_mode_e'(mode);
         s1_clip  <= clip_val;
      end else if (s2_can_load) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         m_zero_cnt <= '0;
      end else if (s2_can_load) begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data     <= act_data;
            m_last     <= s1_last;
            m_zero_cnt <= cnt_next;
         end else if (m_fire_last) begin
            m_zero_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_act_pipe.sv
// tb_act_pipe: directed self-checking bench for act_pipe (DATA_W=8, CH=4).
module tb_act_pipe;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic [7:0]  clip_val;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic [15:0] m_zero_cnt;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic [15:0] cnt;
      logic        cc;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          occ    = 0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;
   logic [15:0] hold_c;

   act_pipe #(
      .DATA_W      (8),
      .CH          (4),
      .LEAKY_SHIFT (3),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .clip_val   (clip_val),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_zero_cnt (m_zero_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Output monitor: compares handed-off beats against the expected queue,
   // checks s_ready against an occupancy model and checks stalled outputs hold.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         occ    = 0;
         hold_v = 1'b0;
      end else begin
         chk("s_ready", s_ready, !(occ == 2 && !m_ready));
         if (hold_v) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, hold_d);
            chk("hold_last", m_last, hold_l);
            chk("hold_cnt", m_zero_cnt, hold_c);
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
         hold_l = m_last;
         hold_c = m_zero_cnt;
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               chk("extra_beat", m_data, 32'hxxxxxxxx);
            end else begin
               e = expq.pop_front();
               chk("data", m_data, e.d);
               chk("last", m_last, e.last);
               if (e.cc) chk("zero_cnt", m_zero_cnt, e.cnt);
            end
         end
         occ = occ + int'(s_valid && s_ready) - int'(m_valid && m_ready);
      end
   end

   task automatic send(input logic [31:0] d, input logic [1:0] md, input logic [7:0] cv,
                       input logic lst, input logic [31:0] ed, input logic [15:0] ec,
                       input logic ecc);
      int n = 0;
      s_valid  = 1'b1;
      s_data   = d;
      mode     = md;
      clip_val = cv;
      s_last   = lst;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("send_timeout", s_ready, 1'b1);
      end else begin
         expq.push_back('{d: ed, last: lst, cnt: ec, cc: ecc});
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (expq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", expq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] pat;
      pat      = 4'b1001;
      rst_n    = 1'b0;
      m_ready  = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      mode     = 2'd0;
      clip_val = '0;

      repeat (2) @(negedge clk);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_zero_cnt", m_zero_cnt, 16'h0);
      chk("rst_s_ready", s_ready, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1'b1);
      @(posedge clk);
      #1;

      // ReLU with latency check
      send(32'h800700FB, 2'd1, 8'h00, 1'b1, 32'h00070000, 16'd3, 1'b1);
      @(negedge clk);
      chk("lat_cycle1_valid", m_valid, 1'b0);
      @(negedge clk);
      chk("lat_cycle2_valid", m_valid, 1'b1);
      wait_drain();

      // clipped ReLU, positive and negative clip
      send(32'h7F0706FF, 2'd2, 8'h06, 1'b1, 32'h06060600, 16'd1, 1'b1);
      send(32'h7F0706FF, 2'd2, 8'hFD, 1'b1, 32'h00000000, 16'd4, 1'b1);
      // leaky and bypass
      send(32'h32F7F8FF, 2'd3, 8'h00, 1'b1, 32'h32FEFFFF, 16'd0, 1'b1);
      send(32'h01007F80, 2'd0, 8'h00, 1'b1, 32'h01007F80, 16'd1, 1'b1);
      wait_drain();

      // 3-beat frame, then a zero-free frame, then back-to-back frames
      send(32'h00030201, 2'd1, 8'h00, 1'b0, 32'h00030201, 16'd1, 1'b0);
      send(32'h0605FEFF, 2'd1, 8'h00, 1'b0, 32'h06050000, 16'd3, 1'b0);
      send(32'h9CFDFF00, 2'd1, 8'h00, 1'b1, 32'h00000000, 16'd7, 1'b1);
      send(32'h01010101, 2'd1, 8'h00, 1'b1, 32'h01010101, 16'd0, 1'b1);
      send(32'hFFFFFFFF, 2'd1, 8'h00, 1'b1, 32'h00000000, 16'd4, 1'b1);
      send(32'h01010100, 2'd1, 8'h00, 1'b0, 32'h01010100, 16'd1, 1'b0);
      send(32'h00050505, 2'd1, 8'h00, 1'b1, 32'h00050505, 16'd2, 1'b1);
      wait_drain();

      // backpressure: m_ready toggles 1-0-0-1 while 10 counting beats stream in
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               logic [31:0] d;
               d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
               send(d, 2'd0, 8'h00, (k == 9), d, 16'd1, (k == 9));
            end
         end
         begin
            for (int c = 0; c < 60; c++) begin
               m_ready = pat[c % 4];
               @(posedge clk);
               #1;
            end
            m_ready = 1'b1;
         end
      join
      wait_drain();

      // reset with both stages full
      m_ready = 1'b0;
      send(32'h00000000, 2'd1, 8'h00, 1'b0, 32'h0, 16'd4, 1'b0);
      send(32'h00000000, 2'd1, 8'h00, 1'b0, 32'h0, 16'd8, 1'b0);
      @(negedge clk);
      chk("full_m_valid", m_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_m_valid", m_valid, 1'b0);
      chk("async_zero_cnt", m_zero_cnt, 16'h0);
      chk("async_m_data", m_data, 32'h0);
      chk("async_s_ready", s_ready, 1'b0);
      expq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;
      send(32'h00000001, 2'd1, 8'h00, 1'b1, 32'h00000001, 16'd3, 1'b1);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
